pipe_skid_buf: RTL and testbench

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

---
 rtl/pipe_skid_buf_pkg.sv | 12 +
 rtl/pipe_skid_buf_reg.sv | 19 +
 rtl/pipe_skid_buf.sv | 107 ++++++++++
 tb/tb_pipe_skid_buf.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_buf_pkg.sv
// pipe_skid_buf_pkg: shared state encoding and default width for the skid buffer
package pipe_skid_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_skid_state_t;

    localparam int PIPE_SKID_DW_DEFAULT = 32;

endpackage

// File: rtl/pipe_skid_buf_reg.sv
// skid_reg: DW-wide data register with clock enable and async active-high reset to 0
module skid_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_o <= '0;
        else if (en_i)
            q_o <= d_i;
    end

endmodule

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry registered ready/valid skid buffer with flush
// Define PIPE_SKID_BUF_ASSERT_EN to compile in protocol and state assertions.
module pipe_skid_buf
    import pipe_skid_buf_pkg::*;
#(
    parameter int DW = PIPE_SKID_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o
);

    pipe_skid_state_t state_q, state_d;
    logic             m_valid_q, s_ready_q;
    logic             main_en, skid_en;
    logic [DW-1:0]    main_d, main_q, skid_q;
    logic             in_hs, out_hs;

    assign in_hs  = s_valid_i & s_ready_q;
    assign out_hs = m_valid_q & m_ready_i;
    assign main_d = (state_q == FULL) ? skid_q : s_data_i;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        case (state_q)
            EMPTY: if (in_hs) begin
                state_d = BUSY;
                main_en = 1'b1;
            end
            BUSY: if (in_hs && out_hs) begin
                main_en = 1'b1;
            end else if (in_hs) begin
                state_d = FULL;
                skid_en = 1'b1;
            end else if (out_hs) begin
                state_d = EMPTY;
            end
            FULL: if (out_hs) begin
                state_d = BUSY;
                main_en = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        // flush wins over everything, including a same-cycle input handshake
        if (flush_i) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    // handshake flags are registered copies of the next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            m_valid_q <= (state_d != EMPTY);
            s_ready_q <= (state_d != FULL);
        end
    end

    skid_reg #(.DW(DW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (main_q)
    );

    skid_reg #(.DW(DW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .en_i (skid_en),
        .d_i  (s_data_i),
        .q_o  (skid_q)
    );

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = main_q;

`ifdef PIPE_SKID_BUF_ASSERT_EN
    a_src_stable: assert property (@(posedge clk) disable iff (rst)
        (s_valid_i && !s_ready_o && !flush_i) |=> (s_valid_i && $stable(s_data_i)))
        else $error("source changed while stalled");

    a_no_x: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(s_valid_i) && !$isunknown(m_ready_i))
        else $error("X on handshake input");

    a_no_empty_to_full: assert property (@(posedge clk) disable iff (rst)
        (state_q == EMPTY) |=> (state_q != FULL))
        else $error("EMPTY to FULL transition");
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// tb_pipe_skid_buf: directed bench with a queue-based reference model of the skid buffer
module tb_pipe_skid_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] delivered[$];
    logic          mdl_in, mdl_out;

    pipe_skid_buf #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Two-entry FIFO: holds at most two, accepts while fewer than two, presents the oldest.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            mdl_out = (q.size() != 0) && m_ready;
            mdl_in  = s_valid && (q.size() < 2);
            if (mdl_out) begin
                delivered.push_back(q[0]);
                void'(q.pop_front());
            end
            if (flush)
                q.delete();
            else if (mdl_in)
                q.push_back(s_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", DW'(m_valid), DW'(q.size() != 0));
            chk("s_ready", DW'(s_ready), DW'(q.size() < 2));
            if (q.size() != 0)
                chk("m_data", m_data, q[0]);
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        flush   = f;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int idx;
        int cyc;
        logic acc;
        logic [DW-1:0] saw77;
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset m_valid", DW'(m_valid), 32'd0);
        chk("reset s_ready", DW'(s_ready), 32'd1);
        chk("reset m_data", m_data, 32'd0);

        // single transfer, one-cycle latency
        drive(1'b1, 32'hA5, 1'b1, 1'b0);
        chk("lat m_valid", DW'(m_valid), 32'd1);
        chk("lat m_data", m_data, 32'hA5);
        chk("lat s_ready", DW'(s_ready), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain m_valid", DW'(m_valid), 32'd0);

        // fill both entries while stalled, then release
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        chk("push1 s_ready", DW'(s_ready), 32'd1);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        chk("push2 s_ready", DW'(s_ready), 32'd0);
        chk("push2 m_data", m_data, 32'h11);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("rel1 m_data", m_data, 32'h22);
        chk("rel1 m_valid", DW'(m_valid), 32'd1);
        chk("rel1 s_ready", DW'(s_ready), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("rel2 m_valid", DW'(m_valid), 32'd0);

        // stream 0x00..0x3F with random backpressure
        delivered.delete();
        idx = 0;
        cyc = 0;
        while ((delivered.size() < 64) && (cyc < 2000)) begin
            s_valid = (idx < 64);
            s_data  = DW'(idx);
            m_ready = 1'($urandom_range(0, 1));
            flush   = 1'b0;
            acc     = s_valid && s_ready;
            @(posedge clk);
            #2;
            if (acc) idx++;
            cyc++;
        end
        chk("stream count", DW'(delivered.size()), 32'd64);
        checks++;
        for (int i = 0; i < delivered.size(); i++)
            if (delivered[i] !== DW'(i)) begin
                errors++;
                $display("FAIL stream order: slot %0d got %0h expected %0h", i, delivered[i], i);
                break;
            end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // flush while full discards the concurrent input
        delivered.delete();
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        drive(1'b1, 32'h66, 1'b0, 1'b0);
        chk("full s_ready", DW'(s_ready), 32'd0);
        drive(1'b1, 32'h77, 1'b0, 1'b1);
        chk("flush m_valid", DW'(m_valid), 32'd0);
        chk("flush s_ready", DW'(s_ready), 32'd1);
        saw77 = '0;
        repeat (3) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            if (m_valid && m_data == 32'h77) saw77 = 32'd1;
        end
        chk("flush no 77", saw77, 32'd0);
        chk("flush idle", DW'(m_valid), 32'd0);

        // async reset between edges while BUSY
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        chk("busy m_valid", DW'(m_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async m_valid", DW'(m_valid), 32'd0);
        chk("async s_ready", DW'(s_ready), 32'd1);
        chk("async m_data", m_data, 32'd0);
        s_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post rst m_valid", DW'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
